// File: rtl/mult_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl_if
//
// Purpose : Bundles the handshake and datapath strobe signals that run between
//           the shift-add multiplier sequencer and its surroundings (pin
//           wrapper + datapath).
//
// Signals :
//   start   wrapper -> ctrl   begin a multiply (only looked at in IDLE)
//   flag    datapath -> ctrl  current multiplier LSB from the shift register
//   busy    ctrl -> wrapper   high in every state except IDLE
//   done    ctrl -> wrapper   one-cycle completion pulse
//   enA     ctrl -> datapath  load operand register A
//   enB     ctrl -> datapath  load operand register B
//   enDPO   ctrl -> datapath  load product output register
//   ABsel   ctrl -> datapath  SR parallel-load source (0=A, 1=B)
//   sr_c1/0 ctrl -> datapath  SR mode (00 hold, 01 shr, 10 load, 11 clear)
//   enSR    ctrl -> datapath  SR enable
//   SRsel   ctrl -> datapath  SR shift-in source (0=zero, 1=ACC LSB)
//   alu_c2..0 ctrl -> datapath ALU op (000 pass, 001 ACC+B, 010 {c,ACC}>>1)
//   enACC   ctrl -> datapath  accumulator load
//   clrACC  ctrl -> datapath  accumulator clear
//
// Modports:
//   master : the sequencer (drives busy/done/strobes, receives start/flag)
//   slave  : wrapper/datapath side (drives start/flag, receives the rest)
// -----------------------------------------------------------------------------
interface mult_seq_ctrl_if;
  logic start;
  logic flag;
  logic busy;
  logic done;
  logic enA;
  logic enB;
  logic enDPO;
  logic ABsel;
  logic sr_c1;
  logic sr_c0;
  logic enSR;
  logic SRsel;
  logic alu_c0;
  logic alu_c1;
  logic alu_c2;
  logic enACC;
  logic clrACC;

  modport master (
    input  start,
    input  flag,
    output busy,
    output done,
    output enA,
    output enB,
    output enDPO,
    output ABsel,
    output sr_c1,
    output sr_c0,
    output enSR,
    output SRsel,
    output alu_c0,
    output alu_c1,
    output alu_c2,
    output enACC,
    output clrACC
  );

  modport slave (
    output start,
    output flag,
    input  busy,
    input  done,
    input  enA,
    input  enB,
    input  enDPO,
    input  ABsel,
    input  sr_c1,
    input  sr_c0,
    input  enSR,
    input  SRsel,
    input  alu_c0,
    input  alu_c1,
    input  alu_c2,
    input  enACC,
    input  clrACC
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//
// Purpose : Moore FSM sequencer for a shift-add multiplier datapath. It
//           accepts a start request, loads the operands, clears the
//           accumulator, then for each of the WIDTH multiplier bits tests the
//           LSB (flag), optionally adds B into the accumulator, and shifts
//           {ACC,SR} right by one. After the last shift it loads the product
//           output register and pulses done.
//
// Ports   :
//   sys_clk  in   system clock, rising edge
//   sys_rst  in   synchronous active-high reset (returns to IDLE, cnt=0)
//   bus      mult_seq_ctrl_if.master
//              in : start, flag
//              out: busy, done and the 13 datapath strobes
//
// Parameters:
//   WIDTH  operand width, 2..16; sets the number of bit iterations
//   CNT_W  iteration counter width, derived from WIDTH
//
// Build option:
//   MULT_CONST_LAT_EN  when defined, every bit goes through ADD regardless
//                      of flag (the add is suppressed for zero bits), giving
//                      a data-independent latency of 2 + 3*WIDTH cycles.
//                      When undefined, zero bits skip ADD and latency is
//                      2 + 2*WIDTH + popcount(A).
//
// All outputs come straight from flops: the output word is decoded from the
// next state and registered on the same edge as the state itself, so each
// output is a pure function of the current state with no combinational path
// from start/flag.
// -----------------------------------------------------------------------------
module mult_seq_ctrl #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  mult_seq_ctrl_if.master bus
);

  // Elaboration guard on the legal operand width range.
  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("mult_seq_ctrl: WIDTH must be in 2..16");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_INIT  = 3'd2,
    S_TEST  = 3'd3,
    S_ADD   = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Full registered output word; field order is irrelevant to the datapath.
  typedef struct packed {
    logic busy;
    logic done;
    logic enA;
    logic enB;
    logic enDPO;
    logic ABsel;
    logic sr_c1;
    logic sr_c0;
    logic enSR;
    logic SRsel;
    logic alu_c2;
    logic alu_c1;
    logic alu_c0;
    logic enACC;
    logic clrACC;
  } strobe_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  strobe_t         r_out;

  state_t          w_next;
  strobe_t         w_out_next;
  logic            w_last;
  logic            w_add_en;

  // ---------------------------------------------------------------------------
  // Next-state rule. flag only matters when leaving TEST.
  // ---------------------------------------------------------------------------
  function automatic state_t next_state(input state_t s,
                                        input logic   start,
                                        input logic   flag,
                                        input logic   last);
    state_t n;
    n = s;
    case (s)
      S_IDLE:  n = start ? S_LOAD : S_IDLE;
      S_LOAD:  n = S_INIT;
      S_INIT:  n = S_TEST;
`ifdef MULT_CONST_LAT_EN
      // Every bit takes the same path so latency ignores the operand value.
      S_TEST:  n = S_ADD;
`else
      S_TEST:  n = flag ? S_ADD : S_SHIFT;
`endif
      S_ADD:   n = S_SHIFT;
      S_SHIFT: n = last ? S_DONE : S_TEST;
      S_DONE:  n = S_IDLE;
      default: n = S_IDLE;
    endcase
`ifdef MULT_CONST_LAT_EN
    // flag has no effect on the state sequence in this build.
    n = state_t'(n | (3'd0 & {3{flag}}));
`endif
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Output decode for a given state. add_en qualifies the ADD strobes; it is
  // constant 1 when ADD is only ever entered for a set multiplier bit.
  // ---------------------------------------------------------------------------
  function automatic strobe_t decode(input state_t s, input logic add_en);
    strobe_t o;
    o = '0;
    case (s)
      S_IDLE: begin
      end
      S_LOAD: begin
        o.busy = 1'b1;
        o.enA  = 1'b1;
        o.enB  = 1'b1;
      end
      S_INIT: begin
        // Clear ACC and parallel-load the multiplier A into the SR.
        o.busy   = 1'b1;
        o.clrACC = 1'b1;
        o.enSR   = 1'b1;
        o.sr_c1  = 1'b1;
        o.sr_c0  = 1'b0;
        o.ABsel  = 1'b0;
      end
      S_TEST: begin
        o.busy = 1'b1;
      end
      S_ADD: begin
        // ACC + B when enabled; otherwise alu=000 with the load held off.
        o.busy   = 1'b1;
        o.alu_c0 = add_en;
        o.enACC  = add_en;
      end
      S_SHIFT: begin
        // {carry,ACC} shifts right while the SR shifts in ACC's old LSB.
        o.busy   = 1'b1;
        o.enSR   = 1'b1;
        o.sr_c1  = 1'b0;
        o.sr_c0  = 1'b1;
        o.SRsel  = 1'b1;
        o.alu_c1 = 1'b1;
        o.enACC  = 1'b1;
      end
      S_DONE: begin
        o.busy  = 1'b1;
        o.enDPO = 1'b1;
        o.done  = 1'b1;
      end
      default: begin
      end
    endcase
    return o;
  endfunction

  assign w_last = (r_cnt == LAST_CNT);

`ifdef MULT_CONST_LAT_EN
  // ADD is entered only from TEST, so flag here is the bit being tested.
  assign w_add_en = bus.flag;
`else
  assign w_add_en = 1'b1;
`endif

  assign w_next     = next_state(r_state, bus.start, bus.flag, w_last);
  assign w_out_next = decode(w_next, w_add_en);

  // ---------------------------------------------------------------------------
  // State, iteration counter and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_next;
      r_out   <= w_out_next;
      if (r_state == S_INIT) begin
        r_cnt <= '0;
      end else if (r_state == S_SHIFT && !w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.busy   = r_out.busy;
  assign bus.done   = r_out.done;
  assign bus.enA    = r_out.enA;
  assign bus.enB    = r_out.enB;
  assign bus.enDPO  = r_out.enDPO;
  assign bus.ABsel  = r_out.ABsel;
  assign bus.sr_c1  = r_out.sr_c1;
  assign bus.sr_c0  = r_out.sr_c0;
  assign bus.enSR   = r_out.enSR;
  assign bus.SRsel  = r_out.SRsel;
  assign bus.alu_c0 = r_out.alu_c0;
  assign bus.alu_c1 = r_out.alu_c1;
  assign bus.alu_c2 = r_out.alu_c2;
  assign bus.enACC  = r_out.enACC;
  assign bus.clrACC = r_out.clrACC;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_ctrl
//
// Drives mult_seq_ctrl through reset, fixed-operand and random multiplies.
// A behavioural shift-add datapath reacts to the controller's strobes and
// feeds flag back; the expected product is plain a*b and the expected
// latency comes from the closed-form cycle count.
// -----------------------------------------------------------------------------
module tb_mult_seq_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_r = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl_if ifc ();

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (ifc.master)
  );

  // Behavioural datapath: operand regs, shift register, accumulator + carry,
  // product register.
  logic [W-1:0]   m_a   = '0;
  logic [W-1:0]   m_b   = '0;
  logic [W-1:0]   m_sr  = '0;
  logic [W-1:0]   m_acc = '0;
  logic           m_c   = 1'b0;
  logic [2*W-1:0] m_po  = '0;

  assign ifc.start = start_r;
  assign ifc.flag  = m_sr[0];

  always @(posedge clk) begin
    if (ifc.enA) m_a <= op_a;
    if (ifc.enB) m_b <= op_b;
    if (ifc.clrACC) begin
      m_acc <= '0;
      m_c   <= 1'b0;
    end else if (ifc.enACC) begin
      case ({ifc.alu_c2, ifc.alu_c1, ifc.alu_c0})
        3'b001: {m_c, m_acc} <= {1'b0, m_acc} + {1'b0, m_b};
        3'b010: begin
          m_acc <= {m_c, m_acc[W-1:1]};
          m_c   <= 1'b0;
        end
        default: ;
      endcase
    end
    if (ifc.enSR) begin
      case ({ifc.sr_c1, ifc.sr_c0})
        2'b10:   m_sr <= ifc.ABsel ? m_b : m_a;
        2'b01:   m_sr <= {(ifc.SRsel ? m_acc[0] : 1'b0), m_sr[W-1:1]};
        2'b11:   m_sr <= '0;
        default: ;
      endcase
    end
    if (ifc.enDPO) m_po <= {m_acc, m_sr};
  end

  function automatic int popc(input logic [W-1:0] v);
    return $countones(v);
  endfunction

  function automatic int exp_lat(input logic [W-1:0] a);
`ifdef MULT_CONST_LAT_EN
    return 2 + 3 * W;
`else
    return 2 + 2 * W + popc(a);
`endif
  endfunction

  function automatic logic [14:0] outs();
    return {ifc.busy, ifc.done, ifc.enA, ifc.enB, ifc.enDPO, ifc.ABsel,
            ifc.sr_c1, ifc.sr_c0, ifc.enSR, ifc.SRsel, ifc.alu_c0,
            ifc.alu_c1, ifc.alu_c2, ifc.enACC, ifc.clrACC};
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Entered in the LOAD cycle (#1 after the edge that sampled start).
  // Returns #1 after the edge that leaves DONE.
  task automatic wait_done(input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc  = 0;
    int adds = 0;
    bit seen = 1'b0;
    chk("load_enA", ifc.enA, 1);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (ifc.alu_c0 && ifc.enACC) adds++;
      if (ifc.done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    chk("latency", cyc, exp_lat(a));
    chk("enDPO_with_done", ifc.enDPO, 1);
    chk("busy_in_done", ifc.busy, 1);
    chk("add_count", adds, popc(a));
    @(posedge clk); #1;
    chk("done_one_cycle", ifc.done, 0);
    chk("idle_after_done", ifc.busy, 0);
    chk("product", int'(m_po), int'(a) * int'(b));
  endtask

  // Entered #1 after an edge with the controller in IDLE.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    op_a    = a;
    op_b    = b;
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    wait_done(a, b);
  endtask

  initial begin
    int shifts;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset held with start high: nothing may start.
    op_a    = 4'd5;
    op_b    = 4'd3;
    start_r = 1'b1;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", int'(outs()), 0);
    chk("rst_busy", ifc.busy, 0);
    // First edge without reset honours the pending start.
    rst = 1'b0;
    @(posedge clk); #1;
    start_r = 1'b0;
    wait_done(4'd5, 4'd3);

    // Multiplier zero: no adds, minimum latency.
    launch(4'd0, 4'd9);

    // All ones.
    launch(4'd15, 4'd15);

    // Start held across two back-to-back operations.
    op_a    = 4'd5;
    op_b    = 4'd3;
    start_r = 1'b1;
    @(posedge clk); #1;
    wait_done(4'd5, 4'd3);
    @(posedge clk); #1;
    start_r = 1'b0;
    wait_done(4'd5, 4'd3);

    // Reset in the third SHIFT abandons the multiply.
    op_a    = 4'd15;
    op_b    = 4'd15;
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    shifts  = 0;
    for (int i = 0; i < 100 && shifts < 3; i++) begin
      @(posedge clk); #1;
      if (ifc.enSR && !ifc.sr_c1 && ifc.sr_c0) shifts++;
    end
    chk("third_shift_seen", shifts, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_outs", int'(outs()), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", int'({ifc.done, ifc.busy}), 0);
    end
    launch(4'd7, 4'd11);

    // Random operands.
    for (int k = 0; k < 10; k++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      launch(ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencing controller for the shift-add multiplier datapath (operand registers A/B, shift register, ALU, accumulator, product output register).
- Adds a start/busy/done handshake and a bit-iteration counter.
- Drives the datapath's 13 control strobes from a Moore FSM.
- Sits between the top-level pin wrapper and the datapath; consumes the datapath `flag` (current multiplier LSB).

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16; sets iteration count.
- CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- sys_clk  in  1  system clock, rising edge
- sys_rst  in  1  synchronous active-high reset
- start  in  1  begin a multiply; sampled only in IDLE
- flag  in  1  multiplier LSB from the datapath shift register
- busy  out  1  high in every state except IDLE
- done  out  1  high for exactly one cycle, in DONE state
- enA  out  1  load operand register A
- enB  out  1  load operand register B
- enDPO  out  1  load product output register
- ABsel  out  1  shift-register load source: 0=A, 1=B
- sr_c1  out  1  shift-register mode bit 1
- sr_c0  out  1  shift-register mode bit 0
  - mode encoding: 00 hold, 01 shift right, 10 parallel load, 11 clear
- enSR  out  1  shift-register enable
- SRsel  out  1  shift-in source: 0=zero, 1=accumulator LSB
- alu_c0  out  1  ALU op bit 0
- alu_c1  out  1  ALU op bit 1
- alu_c2  out  1  ALU op bit 2
  - op encoding: 000 pass ACC, 001 ACC+B, 010 {carry,ACC}>>1; others are never driven
- enACC  out  1  accumulator load
- clrACC  out  1  accumulator clear

Behaviour:
- One clock domain (sys_clk), rising edge.
- sys_rst is synchronous and active-high: any edge with sys_rst=1 forces state IDLE and cnt=0. This holds mid-operation; the product in progress is abandoned.
- All outputs are pure Moore decodes of the registered state. There is no input-to-output combinational path.
- In IDLE, all outputs are 0. After reset, all outputs are 0 from the first edge.
- Any output not listed for a state is 0 in that state.
- States and transitions:
  - IDLE: start=1 -> LOAD; otherwise stay in IDLE.
  - LOAD: enA=1, enB=1 -> INIT.
  - INIT: clrACC=1, enSR=1, mode 10, ABsel=0 (multiplier A into SR); cnt<=0 -> TEST.
  - TEST: no strobes. flag=1 -> ADD; flag=0 -> SHIFT.
  - ADD: alu=001, enACC=1 -> SHIFT.
  - SHIFT: enSR=1, mode 01, SRsel=1, alu=010, enACC=1.
    - cnt==WIDTH-1 -> DONE; otherwise cnt<=cnt+1 -> TEST.
  - DONE: enDPO=1, done=1 -> IDLE.
- start is ignored while busy=1; it is neither queued nor counted.
- start held high in IDLE launches a new multiply immediately after DONE. IDLE is visited for one cycle between operations.
- Counter: CNT_W bits, never wraps past WIDTH-1 in normal flow.
- Latency, counted from the edge that samples start in IDLE to the DONE cycle:
  - 2 + 2*WIDTH + popcount(A) cycles.
  - WIDTH=4: A=0 gives 10; A=15 gives 14.
- Edge cases:
  - flag is sampled only in TEST; its value in other states is don't-care.
  - A=0 or B=0 still runs all WIDTH iterations.

Optional Feature:
- Macro: MULT_CONST_LAT_EN.
- Defined: TEST always goes to ADD.
  - ADD drives alu=001, enACC=1 when flag=1.
  - ADD drives alu=000, enACC=0 when flag=0.
  - Latency is fixed at 2 + 3*WIDTH cycles, independent of operand data.
- Undefined: variable latency exactly as specified in Behaviour.

Test Plan:
- Reset: hold sys_rst=1 for 2 cycles with start=1 -> all outputs 0, busy=0, state IDLE; start is not honoured until the first edge with sys_rst=0.
- A=0 (flag always 0), WIDTH=4, pulse start -> visit sequence LOAD, INIT, then 4x (TEST, SHIFT), then DONE; done high on cycle 10 only; no ADD state is visited.
- Datapath model with A=15, B=15 -> four ADD visits, done on cycle 14, enDPO coincident with done, modelled product 225.
- A=5, B=3 with start held high continuously -> product 15, done on cycle 12; next LOAD one cycle after IDLE; second result also 15.
- Assert sys_rst during the third SHIFT -> next edge gives IDLE, outputs 0, no done pulse; a fresh start then yields a correct product.
- With MULT_CONST_LAT_EN defined: A=0 and A=15 each give done on cycle 14; enACC stays 0 in ADD for flag=0 bits.
